// File: rtl/vx_dma_pkg.sv
// Shared types and default widths for the DMA issue path.
// The top and the tag allocator import this package.
package vx_dma_pkg;

   localparam int DMA_ADDR_WIDTH = 32;
   localparam int DMA_SIZE_WIDTH = 16;
   localparam int DMA_NUM_TAGS   = 8;
   localparam int DMA_NUM_WARPS  = 4;
   localparam int DMA_TAG_WIDTH  = $clog2(DMA_NUM_TAGS);

   typedef enum logic {
      DMA_G2L = 1'b0,
      DMA_L2G = 1'b1
   } dma_dir_e;

   typedef struct packed {
      logic [DMA_ADDR_WIDTH-1:0] src;
      logic [DMA_ADDR_WIDTH-1:0] dst;
      logic [DMA_SIZE_WIDTH-1:0] size;
      dma_dir_e                  direction;
   } dma_cmd_t;

   typedef struct packed {
      dma_cmd_t                 cmd;
      logic [DMA_TAG_WIDTH-1:0] tag;
   } dma_req_t;

   // A single warp still needs a one-bit id.
   function automatic int wid_width(input int num_warps);
      return (num_warps > 1) ? $clog2(num_warps) : 1;
   endfunction

endpackage

// File: rtl/vx_dma_tag_alloc.sv
// Free-tag bitmask with lowest-index-first allocation and a single release port.
// Allocation always works from the registered mask, so a tag released this cycle is reusable next cycle.
module vx_dma_tag_alloc
   import vx_dma_pkg::*;
#(
   parameter int NUM_TAGS  = DMA_NUM_TAGS,
   parameter int TAG_WIDTH = $clog2(NUM_TAGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alloc,
   input  logic                 rel_valid,
   input  logic [TAG_WIDTH-1:0] rel_tag,
   output logic                 any_free,
   output logic [TAG_WIDTH-1:0] alloc_tag,
   output logic [NUM_TAGS-1:0]  free_mask
);

   always_comb begin
      alloc_tag = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (free_mask[i]) begin
            alloc_tag = TAG_WIDTH'(i);
         end
      end
   end

   assign any_free = |free_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         free_mask <= '1;
      end else begin
         if (rel_valid) begin
            free_mask[rel_tag] <= 1'b1;
         end
         if (alloc) begin
            free_mask[alloc_tag] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/vx_dma_issue_unit.sv
// DMA initiator front end: tags per-warp commands, holds one request for the engine,
// retires completions by tag and tracks per-warp outstanding transfers.
module vx_dma_issue_unit
   import vx_dma_pkg::*;
#(
   parameter int NUM_WARPS  = DMA_NUM_WARPS,
   parameter int NUM_TAGS   = DMA_NUM_TAGS,
   parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
   parameter int SIZE_WIDTH = DMA_SIZE_WIDTH,
   parameter int TAG_WIDTH  = $clog2(NUM_TAGS),
   parameter int WID_WIDTH  = wid_width(NUM_WARPS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [WID_WIDTH-1:0]  cmd_wid,
   input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
   input  logic [SIZE_WIDTH-1:0] cmd_size,
   input  logic                  cmd_direction,
   output logic                  dma_req_valid,
   input  logic                  dma_req_ready,
   output logic [ADDR_WIDTH-1:0] dma_req_src_addr,
   output logic [ADDR_WIDTH-1:0] dma_req_dst_addr,
   output logic [SIZE_WIDTH-1:0] dma_req_size,
   output logic                  dma_req_direction,
   output logic [TAG_WIDTH-1:0]  dma_req_tag,
   input  logic                  dma_rsp_valid,
   output logic                  dma_rsp_ready,
   input  logic [TAG_WIDTH-1:0]  dma_rsp_tag,
   output logic                  done_valid,
   output logic [WID_WIDTH-1:0]  done_wid,
   output logic [NUM_WARPS-1:0]  wait_pending,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int CNT_WIDTH = $clog2(NUM_TAGS + 1);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]           req_state;
   dma_dir_e             req_direction;
   logic                 any_free;
   logic [TAG_WIDTH-1:0] alloc_tag;
   logic [NUM_TAGS-1:0]  free_mask;
   logic [WID_WIDTH-1:0] tag_wid [NUM_TAGS];
   logic [CNT_WIDTH-1:0] cnt [NUM_WARPS];
   logic [WID_WIDTH-1:0] rsp_wid;
   logic [NUM_WARPS-1:0] inc_mask;
   logic [NUM_WARPS-1:0] dec_mask;
   logic                 accept;
   logic                 alloc;
   logic                 drain;
   logic                 rsp_hit;
   logic                 rsp_miss;

   assign dma_req_valid     = (req_state == ST_FULL);
   assign dma_req_direction = req_direction;
   assign dma_rsp_ready     = !reset;

   assign cmd_ready = any_free && (!dma_req_valid || dma_req_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign alloc     = accept && (cmd_size != '0);
   assign drain     = dma_req_valid && dma_req_ready;
   assign rsp_hit   = dma_rsp_valid && !free_mask[dma_rsp_tag];
   assign rsp_miss  = dma_rsp_valid && free_mask[dma_rsp_tag];
   assign rsp_wid   = tag_wid[dma_rsp_tag];
   assign busy      = !(&free_mask) || dma_req_valid;

   vx_dma_tag_alloc #(
      .NUM_TAGS  (NUM_TAGS),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_tag_alloc (
      .clk       (clk),
      .reset     (reset),
      .alloc     (alloc),
      .rel_valid (rsp_hit),
      .rel_tag   (dma_rsp_tag),
      .any_free  (any_free),
      .alloc_tag (alloc_tag),
      .free_mask (free_mask)
   );

   // A zero-size command is consumed without occupying the request slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_state        <= ST_EMPTY;
         dma_req_src_addr <= '0;
         dma_req_dst_addr <= '0;
         dma_req_size     <= '0;
         req_direction    <= DMA_G2L;
         dma_req_tag      <= '0;
      end else if (alloc) begin
         req_state        <= ST_FULL;
         dma_req_src_addr <= cmd_src_addr;
         dma_req_dst_addr <= cmd_dst_addr;
         dma_req_size     <= cmd_size;
         req_direction    <= dma_dir_e'(cmd_direction);
         dma_req_tag      <= alloc_tag;
      end else if (drain) begin
         req_state        <= ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < NUM_TAGS; t++) begin
            tag_wid[t] <= '0;
         end
      end else if (alloc) begin
         tag_wid[alloc_tag] <= cmd_wid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_valid <= 1'b0;
         done_wid   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         done_valid <= rsp_hit;
         rsp_err    <= rsp_miss;
         if (rsp_hit) begin
            done_wid <= rsp_wid;
         end
      end
   end

   always_comb begin
      inc_mask = '0;
      dec_mask = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         inc_mask[w] = alloc && (cmd_wid == WID_WIDTH'(w));
         dec_mask[w] = rsp_hit && (rsp_wid == WID_WIDTH'(w));
      end
   end

   // An issue and a completion for the same warp cancel out.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            cnt[w] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (inc_mask[w] && !dec_mask[w]) begin
               cnt[w] <= cnt[w] + CNT_WIDTH'(1);
            end else if (dec_mask[w] && !inc_mask[w]) begin
               cnt[w] <= cnt[w] - CNT_WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      wait_pending = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         wait_pending[w] = (cnt[w] != '0);
      end
   end

endmodule
